// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART receiver.
//   state_t    : receive FSM state encoding
//   REG_*      : word offsets of the readable registers
//   VALID etc. : bit positions inside the status register
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int unsigned VALID     = 0;
  localparam int unsigned OVERRUN   = 1;
  localparam int unsigned FRAME_ERR = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter for the UART receiver.
//   clk   : system clock
//   reset : asynchronous active-low reset (counter cleared to 0)
//   load  : reload the counter this cycle
//   half  : with load, reload for half a bit period instead of a full one
//   tick  : high while the counter has expired (count == 0)
// After a load, tick is seen exactly CLKS_PER_BIT (or CLKS_PER_BIT/2)
// rising edges later, so the consumer acts on that edge.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic half,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= half ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with a small memory-mapped register file.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   rx    : serial input, idles high, LSB first
//   addr  : register word address (0 data, 1 status, 2-3 read as zero)
//   re    : read strobe; reading data clears valid, reading status
//           clears overrun and frame_err
//   rdata : combinational read data for addr
//   irq   : high while a received byte is waiting (valid)
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [1:0]  addr,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        irq
);

  // Two-flop synchronizer; resets to the idle (high) line level so a
  // released reset never looks like a start bit.
  logic rx_s1, rxs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
    end
  end

  state_t      state, state_d;
  logic [2:0]  bitcnt, bitcnt_d;
  logic [7:0]  shift, shift_d;
  logic [7:0]  data_reg, data_reg_d;
  logic        valid, valid_d;
  logic        overrun, overrun_d;
  logic        frame_err, frame_err_d;
  logic        bload, bhalf, tick;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .load (bload),
    .half (bhalf),
    .tick (tick)
  );

  logic rd_data, rd_stat, stop_good, stop_bad;

  assign rd_data = re && (addr == REG_DATA);
  assign rd_stat = re && (addr == REG_STATUS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shift     <= '0;
      data_reg  <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      bitcnt    <= bitcnt_d;
      shift     <= shift_d;
      data_reg  <= data_reg_d;
      valid     <= valid_d;
      overrun   <= overrun_d;
      frame_err <= frame_err_d;
    end
  end

  always_comb begin
    state_d   = state;
    bitcnt_d  = bitcnt;
    shift_d   = shift;
    bload     = 1'b0;
    bhalf     = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_d  = START;
          bitcnt_d = '0;
          bload    = 1'b1;
          bhalf    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = rxs ? IDLE : DATA;
          bload   = 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d  = {rxs, shift[7:1]};
          bitcnt_d = bitcnt + 3'd1;
          bload    = 1'b1;
          if (bitcnt == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d   = IDLE;
          stop_good = rxs;
          stop_bad  = !rxs;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flag updates: a set on the same edge as a clearing read wins. A data
  // read coinciding with a good stop frees the holding register, so the
  // new byte is loaded rather than counted as an overrun.
  always_comb begin
    data_reg_d  = data_reg;
    valid_d     = valid;
    overrun_d   = overrun;
    frame_err_d = frame_err;

    if (rd_data) valid_d = 1'b0;
    if (rd_stat) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end

    if (stop_good) begin
      if (!valid || rd_data) begin
        data_reg_d = shift;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (stop_bad) frame_err_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_DATA:   rdata[7:0] = data_reg;
      REG_STATUS: begin
        rdata[VALID]     = valid;
        rdata[OVERRUN]   = overrun;
        rdata[FRAME_ERR] = frame_err;
      end
      default:    rdata = '0;
    endcase
  end

  assign irq = valid;

endmodule
